// File: rtl/debounce_pkg.sv
// Shared definitions for the two-channel switch debouncer.
// Holds the per-channel FSM state encodings and the default debounce length.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LO = 2'b00,
      WAIT_HI   = 2'b01,
      STABLE_HI = 2'b10,
      WAIT_LO   = 2'b11
   } deb_state_t;

   // 10 ms at 50 MHz
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: two-flop synchronizer, accept/reject FSM with a
// saturating hold counter, registered level and single-cycle edge pulses.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_meta;
   logic          sync_q;
   deb_state_t    state;
   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         sync_q    <= 1'b0;
         state     <= STABLE_LO;
         count     <= '0;
         level     <= 1'b0;
         rise      <= 1'b0;
         fall      <= 1'b0;
      end else begin
         sync_meta <= sw;
         sync_q    <= sync_meta;
         rise      <= 1'b0;
         fall      <= 1'b0;
         case (state)
            STABLE_LO: begin
               if (sync_q) begin
                  state <= WAIT_HI;
                  count <= '0;
               end
            end
            WAIT_HI: begin
               if (!sync_q) begin
                  state <= STABLE_LO;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  // Level has held long enough: commit and pulse on the same edge
                  state <= STABLE_HI;
                  count <= '0;
                  level <= 1'b1;
                  rise  <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end
            STABLE_HI: begin
               if (!sync_q) begin
                  state <= WAIT_LO;
                  count <= '0;
               end
            end
            WAIT_LO: begin
               if (sync_q) begin
                  state <= STABLE_HI;
                  count <= '0;
               end else if (count == CNT_MAX) begin
                  state <= STABLE_LO;
                  count <= '0;
                  level <= 1'b0;
                  fall  <= 1'b1;
               end else begin
                  count <= count + CW'(1);
               end
            end
            default: begin
               state <= STABLE_LO;
               count <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Two independent debounced switch channels (A = bit 0, B = bit 1) feeding
// the logic-gate stage, with per-channel rise/fall pulses.
module switch_debouncer
   import debounce_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic       clk_in,
   input  logic       rst_n_in,
   input  logic [1:0] sw_in,
   output logic       a_out,
   output logic       b_out,
   output logic [1:0] rise_out,
   output logic [1:0] fall_out
);

   logic [1:0] level;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_chan (
            .clk  (clk_in),
            .rst_n(rst_n_in),
            .sw   (sw_in[gi]),
            .level(level[gi]),
            .rise (rise_out[gi]),
            .fall (fall_out[gi])
         );
      end
   endgenerate

   assign a_out = level[0];
   assign b_out = level[1];

endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer with DEBOUNCE_CYCLES=4: directed
// scenarios with fixed edge expectations plus random stimulus against a run-length model.
module tb_switch_debouncer;

   localparam int unsigned DC  = 4;
   localparam int          LAT = DC + 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] sw = 2'b00;
   logic       a_out;
   logic       b_out;
   logic [1:0] rise_out;
   logic [1:0] fall_out;

   int checks = 0;
   int errors = 0;

   switch_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
      .clk_in  (clk),
      .rst_n_in(rst_n),
      .sw_in   (sw),
      .a_out   (a_out),
      .b_out   (b_out),
      .rise_out(rise_out),
      .fall_out(fall_out)
   );

   always #5 clk = ~clk;

   // Reference model: the FSM sees the raw level from two edges earlier; an
   // output flips once it has seen DC+1 consecutive samples opposite to it.
   logic [1:0] m_out  = 2'b00;
   logic [1:0] m_rise = 2'b00;
   logic [1:0] m_fall = 2'b00;
   logic [1:0] m_view;
   int         m_run [2] = '{0, 0};
   logic [1:0] hist [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_out  = 2'b00;
         m_rise = 2'b00;
         m_fall = 2'b00;
         m_run  = '{0, 0};
         hist.delete();
      end else begin
         hist.push_back(sw);
         if (hist.size() > 3) void'(hist.pop_front());
         m_view = (hist.size() == 3) ? hist[0] : 2'b00;
         m_rise = 2'b00;
         m_fall = 2'b00;
         for (int i = 0; i < 2; i++) begin
            if (m_view[i] != m_out[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DC + 1) begin
               m_out[i] = m_view[i];
               if (m_view[i]) m_rise[i] = 1'b1;
               else m_fall[i] = 1'b1;
               m_run[i] = 0;
            end
         end
      end
   end

   task automatic test_reset();
      logic [1:0] exp_lvl, exp_r;
      sw    = 2'b11;
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({b_out, a_out, rise_out, fall_out} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: got b,a=%b%b rise=%b fall=%b, want all 0", b_out, a_out, rise_out, fall_out);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk);
         exp_lvl = (e >= LAT) ? 2'b11 : 2'b00;
         exp_r   = (e == LAT) ? 2'b11 : 2'b00;
         checks++;
         if ({b_out, a_out} !== exp_lvl || rise_out !== exp_r || fall_out !== 2'b00) begin
            errors++;
            $display("FAIL reset_release edge %0d: got b,a=%b%b rise=%b fall=%b, want %b rise=%b fall=00",
                     e, b_out, a_out, rise_out, fall_out, exp_lvl, exp_r);
         end
         checks++;
         if ({b_out, a_out} !== m_out || rise_out !== m_rise || fall_out !== m_fall) begin
            errors++;
            $display("FAIL reset_model: got b,a=%b%b rise=%b fall=%b, want %b rise=%b fall=%b",
                     b_out, a_out, rise_out, fall_out, m_out, m_rise, m_fall);
         end
      end
      $display("test_reset done: checks=%0d", checks);
   endtask

   task automatic test_simultaneous_fall();
      logic [1:0] exp_lvl, exp_f;
      sw = 2'b00;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk);
         exp_lvl = (e >= LAT) ? 2'b00 : 2'b11;
         exp_f   = (e == LAT) ? 2'b11 : 2'b00;
         checks++;
         if ({b_out, a_out} !== exp_lvl || fall_out !== exp_f || rise_out !== 2'b00) begin
            errors++;
            $display("FAIL both_fall edge %0d: got b,a=%b%b rise=%b fall=%b, want %b rise=00 fall=%b",
                     e, b_out, a_out, rise_out, fall_out, exp_lvl, exp_f);
         end
      end
      $display("test_simultaneous_fall done: checks=%0d", checks);
   endtask

   task automatic test_clean_rise();
      logic [1:0] exp_r;
      logic       exp_a;
      sw = 2'b01;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk);
         exp_a = (e >= LAT);
         exp_r = (e == LAT) ? 2'b01 : 2'b00;
         checks++;
         if (a_out !== exp_a || b_out !== 1'b0 || rise_out !== exp_r || fall_out !== 2'b00) begin
            errors++;
            $display("FAIL clean_rise edge %0d: got b,a=%b%b rise=%b fall=%b, want 0%b rise=%b fall=00",
                     e, b_out, a_out, rise_out, fall_out, exp_a, exp_r);
         end
      end
      $display("test_clean_rise done: checks=%0d", checks);
   endtask

   task automatic test_glitch_low();
      for (int c = 0; c < 14; c++) begin
         if (c == 0) sw = 2'b00;
         if (c == 2) sw = 2'b01;
         @(negedge clk);
         checks++;
         if (a_out !== 1'b1 || b_out !== 1'b0 || rise_out !== 2'b00 || fall_out !== 2'b00) begin
            errors++;
            $display("FAIL glitch_low cycle %0d: got b,a=%b%b rise=%b fall=%b, want 01 rise=00 fall=00",
                     c, b_out, a_out, rise_out, fall_out);
         end
      end
      $display("test_glitch_low done: checks=%0d", checks);
   endtask

   task automatic test_bounce_rise();
      int         pulses;
      logic [1:0] exp_r;
      sw = 2'b00;
      for (int c = 0; c < LAT + 3; c++) begin
         @(negedge clk);
         checks++;
         if ({b_out, a_out} !== m_out || rise_out !== m_rise || fall_out !== m_fall) begin
            errors++;
            $display("FAIL bounce_settle: got b,a=%b%b rise=%b fall=%b, want %b rise=%b fall=%b",
                     b_out, a_out, rise_out, fall_out, m_out, m_rise, m_fall);
         end
      end
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         sw = (c < 3) ? 2'b01 : 2'b00;
         @(negedge clk);
         if (rise_out[0]) pulses++;
         checks++;
         if (a_out !== 1'b0 || rise_out !== 2'b00) begin
            errors++;
            $display("FAIL bounce_pre cycle %0d: got a=%b rise=%b, want a=0 rise=00", c, a_out, rise_out);
         end
      end
      sw = 2'b01;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk);
         if (rise_out[0]) pulses++;
         exp_r = (e == LAT) ? 2'b01 : 2'b00;
         checks++;
         if (a_out !== (e >= LAT) || rise_out !== exp_r || fall_out !== 2'b00) begin
            errors++;
            $display("FAIL bounce_rise edge %0d: got a=%b rise=%b fall=%b, want a=%b rise=%b fall=00",
                     e, a_out, rise_out, fall_out, (e >= LAT), exp_r);
         end
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL bounce_pulse_count: got %0d rise pulses, want 1", pulses);
      end
      $display("test_bounce_rise done: checks=%0d", checks);
   endtask

   task automatic test_reset_abort();
      logic [1:0] exp_lvl, exp_r;
      sw = 2'b11;
      for (int e = 1; e <= 4; e++) begin
         @(negedge clk);
         checks++;
         if (b_out !== 1'b0 || rise_out[1] !== 1'b0) begin
            errors++;
            $display("FAIL abort_wait edge %0d: got b=%b rise1=%b, want b=0 rise1=0", e, b_out, rise_out[1]);
         end
      end
      rst_n = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({b_out, a_out, rise_out, fall_out} !== 6'b0) begin
            errors++;
            $display("FAIL abort_reset cycle %0d: got b,a=%b%b rise=%b fall=%b, want all 0",
                     c, b_out, a_out, rise_out, fall_out);
         end
      end
      rst_n = 1'b1;
      for (int e = 1; e <= LAT + 3; e++) begin
         @(negedge clk);
         exp_lvl = (e >= LAT) ? 2'b11 : 2'b00;
         exp_r   = (e == LAT) ? 2'b11 : 2'b00;
         checks++;
         if ({b_out, a_out} !== exp_lvl || rise_out !== exp_r || fall_out !== 2'b00) begin
            errors++;
            $display("FAIL abort_release edge %0d: got b,a=%b%b rise=%b fall=%b, want %b rise=%b fall=00",
                     e, b_out, a_out, rise_out, fall_out, exp_lvl, exp_r);
         end
      end
      $display("test_reset_abort done: checks=%0d", checks);
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 2; i++)
            if ($urandom_range(0, 5) == 0) sw[i] = ~sw[i];
         @(negedge clk);
         checks++;
         if ({b_out, a_out} !== m_out || rise_out !== m_rise || fall_out !== m_fall) begin
            errors++;
            $display("FAIL random cycle %0d: got b,a=%b%b rise=%b fall=%b, want %b rise=%b fall=%b",
                     c, b_out, a_out, rise_out, fall_out, m_out, m_rise, m_fall);
         end
         checks++;
         if ((rise_out & fall_out) !== 2'b00) begin
            errors++;
            $display("FAIL random_exclusive cycle %0d: rise=%b fall=%b overlap, want 00", c, rise_out, fall_out);
         end
      end
      $display("test_random done: checks=%0d", checks);
   endtask

   initial begin
      test_reset();
      test_simultaneous_fall();
      test_clean_rise();
      test_glitch_low();
      test_bounce_rise();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
